ga_generation_sequencer: RTL
============================

Name: ga_generation_sequencer

Overview:
- Parametrised successor to the population-level network controller.
- Sequences one genetic-algorithm generation per loop: INIT, RUN, SORT, CROSS, optional MUTATE.
- Runs each network of the population individually in RUN, with a start/done handshake.
- Adds a generation limit, an early stop on a fitness target, a pause input, and a per-phase watchdog. Sits between the top-level controller and the network/sort/crossover/mutation engines.

Parameters:
- NETWORKS_PER_POPULATION, 16, number of networks evaluated per generation (>=1)
- NET_IDX_W, 5, width of active_network (must hold NETWORKS_PER_POPULATION-1)
- GEN_W, 8, width of generation_counter
- MAX_GENERATIONS, 0, stop after this many completed generations; 0 = run forever
- MUTATE_EN, 1, 1 = MUTATE phase follows CROSS; 0 = CROSS returns directly to RUN
- TIMEOUT_W, 16, width of watchdog counter; phase timeout = 2^TIMEOUT_W-1 cycles

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  level; leaving IDLE requires start=1
- pause  in  1  level; freezes sequencing (see Behaviour)
- target_reached  in  1  fitness target met, sampled only on the last net_done of a generation
- phase_start  out  1  one-cycle pulse on entry to INIT/SORT/CROSS/MUTATE
- phase_done  in  1  completion from the engine of the current phase
- net_start  out  1  one-cycle pulse launching network active_network
- net_done  in  1  completion of the running network
- active_network  out  NET_IDX_W  index of network under evaluation
- network_state  out  3  0 IDLE, 1 INIT, 2 RUN, 3 SORT, 4 CROSS, 5 MUTATE, 6 DONE, 7 ERROR
- generation_counter  out  GEN_W  completed generations
- busy  out  1  high in every state except IDLE/DONE/ERROR
- timeout_err  out  1  sticky; set on entry to ERROR

Behaviour:
- Reset (async assert, sync release): network_state=IDLE; active_network=0; generation_counter=0; phase_start=0; net_start=0; busy=0; timeout_err=0; watchdog=0. Reset mid-phase abandons the phase; no pulse is emitted.
- IDLE: when start=1 -> INIT, with phase_start=1 on the first INIT cycle.
- INIT: on phase_done -> RUN with active_network=0; net_start=1 on the first RUN cycle.
- RUN:
  - Each net_done with active_network<N-1 increments active_network; net_start pulses the next cycle.
  - net_done with active_network=N-1: if target_reached=1 -> DONE; else -> SORT with phase_start pulse.
  - generation_counter does not change on the RUN exit.
- SORT: on phase_done -> CROSS with phase_start pulse.
- CROSS: on phase_done -> MUTATE (MUTATE_EN=1, with phase_start pulse); otherwise completes the generation.
- MUTATE: on phase_done, completes the generation.
- Generation completion:
  - generation_counter increments, wrapping modulo 2^GEN_W.
  - If MAX_GENERATIONS!=0 and the new value equals MAX_GENERATIONS -> DONE.
  - Otherwise -> RUN with active_network=0 and a net_start pulse.
- DONE: holds. start falling to 0 -> IDLE; generation_counter is retained until the next IDLE->INIT, where it clears.
- ERROR: entered when the watchdog saturates. Sets timeout_err. Held until reset.
- Latency:
  - Handshake edge to state change: 1 cycle.
  - Start pulses are registered and fall in the first cycle of the new state/network.
  - phase_done and net_done are ignored in the cycle their start pulse is high.
- Done inputs are honoured only in the matching state. phase_done in RUN and net_done outside RUN are ignored.
- Pause:
  - While pause=1, no state transition occurs and the watchdog holds.
  - Done inputs arriving during pause are latched (one pending flag each) and acted on in the first unpaused cycle.
  - A start pulse due during pause is deferred to the first unpaused cycle.
- Watchdog:
  - Clears on every state change and every net_start.
  - Counts in INIT/RUN/SORT/CROSS/MUTATE.
  - Reaching all-ones -> ERROR the next cycle.
- N=1: each net_done in RUN is the last network of the generation.

Decomposition:
- Shared package ga_pkg holds the state encodings (the 3-bit network_state values above), reused by the engines and the debug mux.
- One natural sub-module: ga_watchdog (clear, enable, hold inputs; saturating counter; expired output).

Test Plan:
- N=4, MUTATE_EN=1, engines ack 3 cycles after each start -> net_start pulses for networks 0,1,2,3, then SORT, CROSS, MUTATE; generation_counter 0->1; RUN resumes with active_network=0.
- MAX_GENERATIONS=3 -> DONE after the 3rd MUTATE phase_done with generation_counter=3, busy=0; dropping start -> IDLE; start again -> counter clears to 0.
- target_reached=1 on the 4th net_done of generation 2 -> DONE directly; no SORT phase_start; generation_counter stays 2.
- pause=1 asserted in SORT, phase_done pulsed during pause, pause released 10 cycles later -> CROSS entered 1 cycle after release; watchdog value unchanged across the pause.
- TIMEOUT_W=4, no phase_done in CROSS -> ERROR 16 cycles after entry; timeout_err=1, busy=0; only rst_n recovers.
- rst_n asserted mid-RUN at active_network=2 -> all outputs reset asynchronously; no net_start pulse after release until start is reasserted.

Source files
------------

// File: rtl/ga_pkg.sv
// Shared encodings for the GA generation sequencer and the engines around it.
// network_state values are architectural and are reused by the debug mux.
package ga_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_INIT   = 3'd1;
    localparam logic [2:0] ST_RUN    = 3'd2;
    localparam logic [2:0] ST_SORT   = 3'd3;
    localparam logic [2:0] ST_CROSS  = 3'd4;
    localparam logic [2:0] ST_MUTATE = 3'd5;
    localparam logic [2:0] ST_DONE   = 3'd6;
    localparam logic [2:0] ST_ERROR  = 3'd7;

    function automatic logic is_busy(input logic [2:0] st);
        return !(st == ST_IDLE || st == ST_DONE || st == ST_ERROR);
    endfunction

    // States whose exit is driven by an engine phase_done handshake.
    function automatic logic is_phase(input logic [2:0] st);
        return (st == ST_INIT || st == ST_SORT || st == ST_CROSS || st == ST_MUTATE);
    endfunction

endpackage

// File: rtl/ga_generation_sequencer_if.sv
// Handshake bundle between the sequencer and its controller/engines.
// master = controller and engines side, slave = the sequencer itself.
interface ga_generation_sequencer_if #(
    parameter int NET_IDX_W = 5,
    parameter int GEN_W     = 8
);
    logic                 start;
    logic                 pause;
    logic                 target_reached;
    logic                 phase_start;
    logic                 phase_done;
    logic                 net_start;
    logic                 net_done;
    logic [NET_IDX_W-1:0] active_network;
    logic [2:0]           network_state;
    logic [GEN_W-1:0]     generation_counter;
    logic                 busy;
    logic                 timeout_err;

    modport master (
        output start, pause, target_reached, phase_done, net_done,
        input  phase_start, net_start, active_network, network_state,
               generation_counter, busy, timeout_err
    );

    modport slave (
        input  start, pause, target_reached, phase_done, net_done,
        output phase_start, net_start, active_network, network_state,
               generation_counter, busy, timeout_err
    );
endinterface

// File: rtl/ga_watchdog.sv
// Saturating per-phase watchdog: clear wins, then count while enabled and not held.
// expired_o is high while the counter sits at all-ones.
module ga_watchdog #(
    parameter int TIMEOUT_W = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic enable_i,
    input  logic hold_i,
    output logic expired_o
);

    logic [TIMEOUT_W-1:0] count_q, count_d;

    assign expired_o = &count_q;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && !hold_i && !expired_o) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/ga_generation_sequencer.sv
// Sequences GA generations: INIT, RUN (one network at a time), SORT, CROSS, MUTATE.
// Adds generation limit, fitness early stop, pause with pending done flags, and a watchdog.
module ga_generation_sequencer
    import ga_pkg::*;
#(
    parameter int NETWORKS_PER_POPULATION = 16,
    parameter int NET_IDX_W               = 5,
    parameter int GEN_W                   = 8,
    parameter int MAX_GENERATIONS         = 0,
    parameter int MUTATE_EN               = 1,
    parameter int TIMEOUT_W               = 16
) (
    input logic                      clk,
    input logic                      rst_n,
    ga_generation_sequencer_if.slave bus
);

    localparam logic [NET_IDX_W-1:0] LAST_NET  = NET_IDX_W'(NETWORKS_PER_POPULATION - 1);
    localparam logic [GEN_W-1:0]     GEN_LIMIT = GEN_W'(MAX_GENERATIONS);

    logic [1:0]           rst_sync_q;
    logic                 rst_sync_n;
    logic [2:0]           state_q, state_d;
    logic [NET_IDX_W-1:0] active_q, active_d;
    logic [GEN_W-1:0]     gen_q, gen_d, gen_next;
    logic                 ps_pend_q, ps_pend_d;
    logic                 ns_pend_q, ns_pend_d;
    logic                 pd_pend_q, pd_pend_d;
    logic                 nd_pend_q, nd_pend_d;
    logic                 terr_q, terr_d;
    logic                 phase_done_eff, net_done_eff;
    logic                 complete, wd_clear, wd_expired;

    // Reset asserts immediately but releases on a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end
    assign rst_sync_n = rst_sync_q[1];

    assign gen_next = gen_q + 1'b1;

    // Start pulses stay pending while paused; done inputs are blind while their start is pending.
    assign phase_done_eff = pd_pend_q | (bus.phase_done & is_phase(state_q) & ~ps_pend_q);
    assign net_done_eff   = nd_pend_q | (bus.net_done & (state_q == ST_RUN) & ~ns_pend_q);

    always_comb begin
        // NOTE: every next-state signal takes its hold value first so no latch is inferred.
        state_d   = state_q;
        active_d  = active_q;
        gen_d     = gen_q;
        ps_pend_d = ps_pend_q;
        ns_pend_d = ns_pend_q;
        pd_pend_d = pd_pend_q;
        nd_pend_d = nd_pend_q;
        terr_d    = terr_q;
        complete  = 1'b0;
        wd_clear  = 1'b0;

        if (bus.pause) begin
            pd_pend_d = phase_done_eff;
            nd_pend_d = net_done_eff;
        end else begin
            pd_pend_d = 1'b0;
            nd_pend_d = 1'b0;
            ps_pend_d = 1'b0;
            ns_pend_d = 1'b0;
            if (wd_expired && is_busy(state_q)) begin
                state_d = ST_ERROR;
                terr_d  = 1'b1;
            end else begin
                case (state_q)
                    ST_IDLE: if (bus.start) begin
                        state_d   = ST_INIT;
                        gen_d     = '0;
                        active_d  = '0;
                        ps_pend_d = 1'b1;
                    end
                    ST_INIT: if (phase_done_eff) begin
                        state_d   = ST_RUN;
                        active_d  = '0;
                        ns_pend_d = 1'b1;
                    end
                    ST_RUN: if (net_done_eff) begin
                        if (active_q == LAST_NET) begin
                            if (bus.target_reached) begin
                                state_d = ST_DONE;
                            end else begin
                                state_d   = ST_SORT;
                                ps_pend_d = 1'b1;
                            end
                        end else begin
                            active_d  = active_q + 1'b1;
                            ns_pend_d = 1'b1;
                        end
                    end
                    ST_SORT: if (phase_done_eff) begin
                        state_d   = ST_CROSS;
                        ps_pend_d = 1'b1;
                    end
                    ST_CROSS: if (phase_done_eff) begin
                        if (MUTATE_EN != 0) begin
                            state_d   = ST_MUTATE;
                            ps_pend_d = 1'b1;
                        end else begin
                            complete = 1'b1;
                        end
                    end
                    ST_MUTATE: if (phase_done_eff) complete = 1'b1;
                    ST_DONE:   if (!bus.start) state_d = ST_IDLE;
                    default:   state_d = state_q;
                endcase

                if (complete) begin
                    gen_d = gen_next;
                    if (MAX_GENERATIONS != 0 && gen_next == GEN_LIMIT) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d   = ST_RUN;
                        active_d  = '0;
                        ns_pend_d = 1'b1;
                    end
                end
            end
            wd_clear = (state_d != state_q) || ns_pend_d;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            state_q   <= ST_IDLE;
            active_q  <= '0;
            gen_q     <= '0;
            ps_pend_q <= 1'b0;
            ns_pend_q <= 1'b0;
            pd_pend_q <= 1'b0;
            nd_pend_q <= 1'b0;
            terr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            active_q  <= active_d;
            gen_q     <= gen_d;
            ps_pend_q <= ps_pend_d;
            ns_pend_q <= ns_pend_d;
            pd_pend_q <= pd_pend_d;
            nd_pend_q <= nd_pend_d;
            terr_q    <= terr_d;
        end
    end

    ga_watchdog #(
        .TIMEOUT_W(TIMEOUT_W)
    ) u_wd (
        .clk      (clk),
        .rst_n    (rst_sync_n),
        .clear_i  (wd_clear),
        .enable_i (is_busy(state_q)),
        .hold_i   (bus.pause),
        .expired_o(wd_expired)
    );

    assign bus.phase_start        = ps_pend_q & ~bus.pause;
    assign bus.net_start          = ns_pend_q & ~bus.pause;
    assign bus.active_network     = active_q;
    assign bus.network_state      = state_q;
    assign bus.generation_counter = gen_q;
    assign bus.busy               = is_busy(state_q);
    assign bus.timeout_err        = terr_q;

endmodule
